// File: rtl/phase_sequencer.sv
// Instruction-cycle sequencer: emits one-clock phase strobes per instruction,
// handles run / single-step / halt, and counts completed instructions.
module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int ICNT_W     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec_pulse,
    input  logic                  step_pulse,
    input  logic                  halt_req,
    output logic [NUM_PHASES-1:0] phase,
    output logic [3:0]            tick,
    output logic                  running,
    output logic                  stop_pending,
    output logic [ICNT_W-1:0]     instr_count,
    output logic [NUM_PHASES-1:0] phase_led
);

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(2 * NUM_PHASES - 1);

    state_t              state_q, state_d;
    logic [3:0]          tick_q, tick_d;
    logic                stop_q, stop_d;
    logic [ICNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HALTED;
            tick_q  <= 4'd0;
            stop_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            stop_q  <= stop_d;
            count_q <= count_d;
        end
    end

    // Stops are only honoured at the instruction boundary; a request seen on
    // the boundary tick itself takes effect there and is not carried over.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        stop_d  = stop_q;
        count_d = count_q;
        unique case (state_q)
            HALTED: begin
                tick_d = 4'd0;
                stop_d = 1'b0;
                if (exec_pulse)      state_d = RUN;
                else if (step_pulse) state_d = STEP;
            end
            RUN: begin
                if (tick_q == LAST) begin
                    tick_d  = 4'd0;
                    count_d = count_q + ICNT_W'(1);
                    stop_d  = 1'b0;
                    if (stop_q || exec_pulse || halt_req) state_d = HALTED;
                end else begin
                    tick_d = tick_q + 4'd1;
                    stop_d = stop_q || exec_pulse || halt_req;
                end
            end
            STEP: begin
                if (tick_q == LAST) begin
                    tick_d  = 4'd0;
                    count_d = count_q + ICNT_W'(1);
                    stop_d  = 1'b0;
                    state_d = HALTED;
                end else begin
                    tick_d = tick_q + 4'd1;
                end
            end
            default: begin
                state_d = HALTED;
                tick_d  = 4'd0;
                stop_d  = 1'b0;
            end
        endcase
    end

    assign running      = (state_q != HALTED);
    assign tick         = tick_q;
    assign stop_pending = stop_q;
    assign instr_count  = count_q;

    // Strobes decode the registered tick only, so each is exactly one clock wide.
    always_comb begin
        phase     = '0;
        phase_led = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            phase[p]                  = running && (tick_q == 4'(2 * p));
            phase_led[NUM_PHASES-1-p] = running && (tick_q[3:1] == 3'(p));
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a cycle model plus directed expectations
// feed a scoreboard queue that is drained after every clock edge.
module tb_phase_sequencer;

    localparam int SEL_PHASE   = 0;
    localparam int SEL_TICK    = 1;
    localparam int SEL_RUNNING = 2;
    localparam int SEL_STOP    = 3;
    localparam int SEL_COUNT   = 4;
    localparam int SEL_LED     = 5;
    localparam int SEL_STROBES = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exec_pulse = 1'b0;
    logic        step_pulse = 1'b0;
    logic        halt_req = 1'b0;
    logic [4:0]  phase;
    logic [3:0]  tick;
    logic        running;
    logic        stop_pending;
    logic [15:0] instr_count;
    logic [4:0]  phase_led;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } expT;

    expT sb[$];

    int errors = 0;
    int checks = 0;
    int strobeCount = 0;

    int refState = 0;
    int refTick = 0;
    bit refStop = 1'b0;
    int refCount = 0;

    phase_sequencer #(.NUM_PHASES(5), .ICNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .exec_pulse(exec_pulse),
        .step_pulse(step_pulse),
        .halt_req(halt_req),
        .phase(phase),
        .tick(tick),
        .running(running),
        .stop_pending(stop_pending),
        .instr_count(instr_count),
        .phase_led(phase_led)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] observed(int sel);
        case (sel)
            SEL_PHASE:   return {27'd0, phase};
            SEL_TICK:    return {28'd0, tick};
            SEL_RUNNING: return {31'd0, running};
            SEL_STOP:    return {31'd0, stop_pending};
            SEL_COUNT:   return {16'd0, instr_count};
            SEL_LED:     return {27'd0, phase_led};
            default:     return 32'(strobeCount);
        endcase
    endfunction

    task automatic expectAfter(input string tag, input int sel, input logic [31:0] val);
        sb.push_back('{tag, sel, val});
    endtask

    task automatic checkOutput();
        expT e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observed(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance the reference by one clock from the inputs about to be sampled.
    task automatic modelStep(input bit e, input bit s, input bit h, input bit r);
        bit stopNow;
        if (r) begin
            refState = 0; refTick = 0; refStop = 1'b0; refCount = 0;
        end else if (refState == 0) begin
            if (e)      refState = 1;
            else if (s) refState = 2;
        end else begin
            stopNow = (refState == 1) && (refStop || e || h);
            if (refTick == 9) begin
                refCount = (refCount + 1) % 65536;
                refTick  = 0;
                refStop  = 1'b0;
                if (refState == 2 || stopNow) refState = 0;
            end else begin
                refTick = refTick + 1;
                if (refState == 1) refStop = stopNow;
            end
        end
    endtask

    task automatic applyStimulus(input bit e, input bit s, input bit h, input bit r);
        logic [31:0] expPhase;
        logic [31:0] expLed;
        exec_pulse = e;
        step_pulse = s;
        halt_req   = h;
        reset      = r;
        modelStep(e, s, h, r);
        expPhase = 0;
        expLed   = 0;
        if (refState != 0) begin
            if (refTick % 2 == 0) expPhase = 32'd1 << (refTick / 2);
            expLed = 32'd1 << (4 - refTick / 2);
        end
        expectAfter("model.phase",   SEL_PHASE,   expPhase);
        expectAfter("model.tick",    SEL_TICK,    32'(refTick));
        expectAfter("model.running", SEL_RUNNING, (refState != 0) ? 32'd1 : 32'd0);
        expectAfter("model.stop",    SEL_STOP,    {31'd0, refStop});
        expectAfter("model.count",   SEL_COUNT,   32'(refCount));
        expectAfter("model.led",     SEL_LED,     expLed);
        @(posedge clock);
        #1;
        if (phase != 5'd0) strobeCount++;
        checkOutput();
        exec_pulse = 1'b0;
        step_pulse = 1'b0;
        halt_req   = 1'b0;
        reset      = 1'b0;
    endtask

    initial begin
        $display("[TB] phase_sequencer directed run");

        // Reset state
        applyStimulus(0, 0, 0, 1);
        expectAfter("rst.running", SEL_RUNNING, 0);
        expectAfter("rst.tick",    SEL_TICK,    0);
        expectAfter("rst.phase",   SEL_PHASE,   0);
        expectAfter("rst.led",     SEL_LED,     0);
        expectAfter("rst.count",   SEL_COUNT,   0);
        applyStimulus(0, 0, 0, 1);

        // Run: exec pulse enters RUN with phase[0] on the next clock
        expectAfter("run.phase0",  SEL_PHASE,   5'b00001);
        expectAfter("run.running", SEL_RUNNING, 1);
        expectAfter("run.led",     SEL_LED,     5'b10000);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) expectAfter("run.count1", SEL_COUNT, 1);
            applyStimulus(0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        // Stop request at tick 3 is deferred to the boundary
        expectAfter("stop.pending", SEL_STOP,  1);
        expectAfter("stop.phase2",  SEL_PHASE, 5'b00100);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                expectAfter("stop.halted", SEL_RUNNING, 0);
                expectAfter("stop.count2", SEL_COUNT,   2);
                expectAfter("stop.tick0",  SEL_TICK,    0);
                expectAfter("stop.clear",  SEL_STOP,    0);
            end
            applyStimulus(0, 0, 0, 0);
        end

        // Single step: five strobes, second step pulse ignored
        strobeCount = 0;
        expectAfter("step.running", SEL_RUNNING, 1);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                expectAfter("step.halted",  SEL_RUNNING, 0);
                expectAfter("step.count3",  SEL_COUNT,   3);
                expectAfter("step.strobes", SEL_STROBES, 5);
            end
            applyStimulus(0, (i == 4), 0, 0);
        end
        expectAfter("step.stays", SEL_RUNNING, 0);
        applyStimulus(0, 0, 0, 0);

        // halt_req held around the boundary halts there, then a clean restart
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        expectAfter("halt.halted", SEL_RUNNING, 0);
        expectAfter("halt.clear",  SEL_STOP,    0);
        expectAfter("halt.count4", SEL_COUNT,   4);
        applyStimulus(0, 0, 1, 0);
        expectAfter("halt.ignored", SEL_RUNNING, 0);
        applyStimulus(0, 0, 1, 0);
        expectAfter("halt.restart", SEL_RUNNING, 1);
        expectAfter("halt.nostop",  SEL_STOP,    0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

        // Reset mid-cycle at tick 5
        expectAfter("midrst.tick",    SEL_TICK,    0);
        expectAfter("midrst.phase",   SEL_PHASE,   0);
        expectAfter("midrst.running", SEL_RUNNING, 0);
        expectAfter("midrst.count",   SEL_COUNT,   0);
        applyStimulus(0, 0, 0, 1);

        // exec and step together: exec wins, continuous run
        expectAfter("both.running", SEL_RUNNING, 1);
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 30; i++) begin
            if (i == 29) begin
                expectAfter("both.count3",  SEL_COUNT,   3);
                expectAfter("both.running3", SEL_RUNNING, 1);
            end
            applyStimulus(0, 0, 0, 0);
        end
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0);

        // Stop request on the boundary tick itself stops there
        expectAfter("last.halted", SEL_RUNNING, 0);
        expectAfter("last.clear",  SEL_STOP,    0);
        expectAfter("last.count4", SEL_COUNT,   4);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
